evb_batch_horner: RTL and testbench

Parametrised batch polynomial evaluator for the evaluation accelerator. It evaluates one polynomial of degree N, with coefficients in coefficient memory, at `count` consecutive x values in the data buffer. Evaluation uses an internal Horner multiply-accumulate, so no separate per-point evaluator is needed. Results stream out over a valid/ready port with per-result overflow flags and a batch status word.

---
 rtl/evb_batch_horner_if.sv | 26 ++
 rtl/evb_batch_horner.sv | 202 ++++++++++++++++++++
 tb/tb_evb_batch_horner.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evb_batch_horner_if.sv
// Result stream port of the batch Horner evaluator.
//
// Handshake: the producer raises res_valid together with res_data,
// res_index and res_ovf, and holds all four steady until it sees
// res_ready high at a rising clock edge; that edge is the transfer.
// The consumer may drive res_ready at any time, independent of res_valid.
interface evb_batch_horner_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 6
) ();
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [CNT_W-1:0] res_index;
  logic             res_ovf;

  modport master (
    output res_valid, res_data, res_index, res_ovf,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_data, res_index, res_ovf,
    output res_ready
  );
endinterface

// File: rtl/evb_batch_horner.sv
// Batch polynomial evaluator: evaluates one degree-N polynomial (coefficients
// in an external coefficient memory) at `count` consecutive x values from an
// external data buffer, using a Horner multiply-accumulate. Both memories have
// one-cycle read latency. BUF_DEPTH must be a power of two so the buffer
// address wraps by plain truncation.
module evb_batch_horner #(
  parameter  int DATA_W    = 16,
  parameter  int ACC_W     = 32,
  parameter  int DEG_W     = 5,
  parameter  int BUF_DEPTH = 1024,
  parameter  int MAX_BATCH = 32,
  localparam int ADDR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W     = $clog2(MAX_BATCH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                start,
  input  logic [ADDR_W-1:0]   x_base,
  input  logic [CNT_W-1:0]    count,
  input  logic [DEG_W-1:0]    deg,
  output logic                busy,
  output logic                done,
  output logic                x_rd_en,
  output logic [ADDR_W-1:0]   x_rd_addr,
  input  logic [DATA_W-1:0]   x_rd_data,
  output logic                c_rd_en,
  output logic [DEG_W-1:0]    c_rd_addr,
  input  logic [DATA_W-1:0]   c_rd_data,
  evb_batch_horner_if.master  res,
  output logic [31:0]         status,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    STEP  = 3'd3,
    MAC   = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DEG_W-1:0]    deg_q;
  logic [CNT_W-1:0]    k;
  logic [DEG_W-1:0]    i;
  logic [DATA_W-1:0]   x_reg;
  logic [ACC_W-1:0]    acc;
  logic                ovf;

  logic [ACC_W+DATA_W-1:0] prod;
  logic [ACC_W:0]          sum;
  logic                    step_ovf;

  assign fsm_state = state;

  // One Horner step: full-width product, then add the next coefficient; any
  // bit above ACC_W in either stage is an overflow of this step.
  always_comb begin
    prod     = {{DATA_W{1'b0}}, acc} * {{ACC_W{1'b0}}, x_reg};
    sum      = {1'b0, prod[ACC_W-1:0]} + {{(ACC_W+1-DATA_W){1'b0}}, c_rd_data};
    step_ovf = (|prod[ACC_W+DATA_W-1:ACC_W]) | sum[ACC_W];
  end

  // Batch sequencer; every output is a register updated on state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      x_rd_en       <= 1'b0;
      x_rd_addr     <= '0;
      c_rd_en       <= 1'b0;
      c_rd_addr     <= '0;
      res.res_valid <= 1'b0;
      res.res_data  <= '0;
      res.res_index <= '0;
      res.res_ovf   <= 1'b0;
      status        <= '0;
      base_q        <= '0;
      cnt_q         <= '0;
      deg_q         <= '0;
      k             <= '0;
      i             <= '0;
      x_reg         <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
    end else if (clr) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      x_rd_en       <= 1'b0;
      x_rd_addr     <= '0;
      c_rd_en       <= 1'b0;
      c_rd_addr     <= '0;
      res.res_valid <= 1'b0;
      res.res_data  <= '0;
      res.res_index <= '0;
      res.res_ovf   <= 1'b0;
      status        <= '0;
      base_q        <= '0;
      cnt_q         <= '0;
      deg_q         <= '0;
      k             <= '0;
      i             <= '0;
      x_reg         <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
    end else begin
      x_rd_en <= 1'b0;
      c_rd_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= x_base;
            cnt_q  <= count;
            deg_q  <= deg;
            k      <= '0;
            busy   <= 1'b1;
            if ((count == '0) || (count > CNT_W'(MAX_BATCH))) begin
              // Rejected batch: report the error, skip all memory traffic.
              status <= 32'h0000_0002;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              status    <= '0;
              x_rd_en   <= 1'b1;
              x_rd_addr <= x_base;
              c_rd_en   <= 1'b1;
              c_rd_addr <= deg;
              state     <= FETCH;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          x_reg <= x_rd_data;
          acc   <= {{(ACC_W-DATA_W){1'b0}}, c_rd_data};
          ovf   <= 1'b0;
          i     <= deg_q;
          if (deg_q == '0) begin
            res.res_valid <= 1'b1;
            res.res_data  <= {{(ACC_W-DATA_W){1'b0}}, c_rd_data};
            res.res_index <= k;
            res.res_ovf   <= 1'b0;
            state         <= OUT;
          end else begin
            c_rd_en   <= 1'b1;
            c_rd_addr <= deg_q - DEG_W'(1);
            state     <= STEP;
          end
        end
        STEP: state <= MAC;
        MAC: begin
          acc       <= sum[ACC_W-1:0];
          ovf       <= ovf | step_ovf;
          status[0] <= status[0] | step_ovf;
          i         <= i - DEG_W'(1);
          if (i == DEG_W'(1)) begin
            res.res_valid <= 1'b1;
            res.res_data  <= sum[ACC_W-1:0];
            res.res_index <= k;
            res.res_ovf   <= ovf | step_ovf;
            state         <= OUT;
          end else begin
            c_rd_en   <= 1'b1;
            c_rd_addr <= i - DEG_W'(2);
            state     <= STEP;
          end
        end
        OUT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            status[15:8]  <= status[15:8] + 8'd1;
            if (k == cnt_q - CNT_W'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              k         <= k + CNT_W'(1);
              x_rd_en   <= 1'b1;
              x_rd_addr <= base_q + ADDR_W'(k + CNT_W'(1));
              c_rd_en   <= 1'b1;
              c_rd_addr <= deg_q;
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evb_batch_horner.sv
// Bench for evb_batch_horner: table of directed batches with hand-computed
// results, plus hand-written backpressure, bad-count, clear-priority and
// abort sequences. Memories are simple one-cycle-latency models.
module tb_evb_batch_horner;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        start;
  logic [9:0]  x_base;
  logic [5:0]  count;
  logic [4:0]  deg;
  logic        busy;
  logic        done;
  logic        x_rd_en;
  logic [9:0]  x_rd_addr;
  logic [15:0] x_rd_data;
  logic        c_rd_en;
  logic [4:0]  c_rd_addr;
  logic [15:0] c_rd_data;
  logic [31:0] status;
  logic [2:0]  fsm_state;

  evb_batch_horner_if #(.ACC_W(32), .CNT_W(6)) res_if ();

  evb_batch_horner dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start),
    .x_base    (x_base),
    .count     (count),
    .deg       (deg),
    .busy      (busy),
    .done      (done),
    .x_rd_en   (x_rd_en),
    .x_rd_addr (x_rd_addr),
    .x_rd_data (x_rd_data),
    .c_rd_en   (c_rd_en),
    .c_rd_addr (c_rd_addr),
    .c_rd_data (c_rd_data),
    .res       (res_if),
    .status    (status),
    .fsm_state (fsm_state)
  );

  // clock / memories
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dmem [1024];
  logic [15:0] cmem [32];
  int reads;

  always @(posedge clk) begin
    if (x_rd_en) x_rd_data <= dmem[x_rd_addr];
    if (c_rd_en) c_rd_data <= cmem[c_rd_addr];
  end

  always @(posedge clk) begin
    if (x_rd_en || c_rd_en) reads = reads + 1;
  end

  // scoreboard counters
  int checks;
  int failures;

  typedef struct {
    logic [9:0]        x_base;
    logic [5:0]        count;
    logic [4:0]        deg;
    logic [3:0][15:0]  c;
    logic [3:0][31:0]  exp_res;
    logic [3:0]        exp_ovf;
    logic [31:0]       exp_status;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_x_rd_en"}, {31'd0, x_rd_en}, 32'd0);
    check({tag, "_c_rd_en"}, {31'd0, c_rd_en}, 32'd0);
    check({tag, "_x_rd_addr"}, {22'd0, x_rd_addr}, 32'd0);
    check({tag, "_c_rd_addr"}, {27'd0, c_rd_addr}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, res_if.res_valid}, 32'd0);
    check({tag, "_res_data"}, res_if.res_data, 32'd0);
    check({tag, "_res_index"}, {26'd0, res_if.res_index}, 32'd0);
    check({tag, "_res_ovf"}, {31'd0, res_if.res_ovf}, 32'd0);
    check({tag, "_status"}, status, 32'd0);
  endtask

  // Start a batch and leave the bench one cycle after the sampling edge.
  task automatic kick(input logic [9:0] b, input logic [5:0] n, input logic [4:0] d);
    x_base = b;
    count  = n;
    deg    = d;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int c;
    int nf;
    logic [9:0] ea;
    for (int j = 0; j < 32; j++) cmem[j] = (j < 4) ? v.c[j] : 16'd0;
    res_if.res_ready = 1'b1;
    kick(v.x_base, v.count, v.deg);
    for (int p = 0; p < int'(v.count); p++) begin
      ea = v.x_base + 10'(p);
      c  = 0;
      nf = 0;
      while (!res_if.res_valid && c < 100) begin
        if (x_rd_en) begin
          nf++;
          check($sformatf("v%0d_p%0d_x_rd_addr", id, p), {22'd0, x_rd_addr}, {22'd0, ea});
        end
        step();
        c++;
      end
      check($sformatf("v%0d_p%0d_fetches", id, p), nf, 1);
      check($sformatf("v%0d_p%0d_latency", id, p), c, 2 + 2 * int'(v.deg));
      check($sformatf("v%0d_p%0d_res_data", id, p), res_if.res_data, v.exp_res[p]);
      check($sformatf("v%0d_p%0d_res_index", id, p), {26'd0, res_if.res_index}, p);
      check($sformatf("v%0d_p%0d_res_ovf", id, p), {31'd0, res_if.res_ovf}, {31'd0, v.exp_ovf[p]});
      step();
    end
    check($sformatf("v%0d_done_pulse", id), {31'd0, done}, 32'd1);
    step();
    check($sformatf("v%0d_done_low", id), {31'd0, done}, 32'd0);
    check($sformatf("v%0d_busy_low", id), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_idle", id), {29'd0, fsm_state}, 32'd0);
    check($sformatf("v%0d_status", id), status, v.exp_status);
  endtask

  task automatic bad_count(input logic [5:0] n);
    int r0;
    r0 = reads;
    kick(10'd5, n, 5'd2);
    check($sformatf("bad%0d_done", n), {31'd0, done}, 32'd1);
    check($sformatf("bad%0d_x_rd_en", n), {31'd0, x_rd_en}, 32'd0);
    check($sformatf("bad%0d_c_rd_en", n), {31'd0, c_rd_en}, 32'd0);
    step();
    check($sformatf("bad%0d_done_low", n), {31'd0, done}, 32'd0);
    check($sformatf("bad%0d_busy_low", n), {31'd0, busy}, 32'd0);
    check($sformatf("bad%0d_status", n), status, 32'h0000_0002);
    check($sformatf("bad%0d_reads", n), reads, r0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r0;
    checks   = 0;
    failures = 0;
    reads    = 0;
    rst      = 1'b0;
    clr      = 1'b0;
    start    = 1'b0;
    x_base   = '0;
    count    = '0;
    deg      = '0;
    res_if.res_ready = 1'b1;
    for (int j = 0; j < 1024; j++) dmem[j] = 16'd0;
    for (int j = 0; j < 32; j++) cmem[j] = 16'd0;
    dmem[0]    = 16'd2;
    dmem[1]    = 16'd5;
    dmem[20]   = 16'hFFFF;
    dmem[21]   = 16'd1;
    dmem[30]   = 16'd0;
    dmem[31]   = 16'd1;
    dmem[32]   = 16'd100;
    dmem[40]   = 16'd4;
    dmem[1022] = 16'd3;
    dmem[1023] = 16'd4;

    // Basic: 3x^2+2x+1 at 2,5
    vecs[0] = '{x_base: 10'd0, count: 6'd2, deg: 5'd2,
                c: {16'd0, 16'd3, 16'd2, 16'd1},
                exp_res: {32'd0, 32'd0, 32'd86, 32'd17},
                exp_ovf: 4'b0000, exp_status: 32'h0000_0200};
    // Degree 0: constant 0x1234 three times
    vecs[1] = '{x_base: 10'd10, count: 6'd3, deg: 5'd0,
                c: {16'd0, 16'd0, 16'd0, 16'h1234},
                exp_res: {32'd0, 32'h1234, 32'h1234, 32'h1234},
                exp_ovf: 4'b0000, exp_status: 32'h0000_0300};
    // Overflow: 0xFFFF*x^3 at x=0xFFFF (x^4 mod 2^32) then at x=1
    vecs[2] = '{x_base: 10'd20, count: 6'd2, deg: 5'd3,
                c: {16'hFFFF, 16'd0, 16'd0, 16'd0},
                exp_res: {32'd0, 32'd0, 32'h0000_FFFF, 32'hFFFC_0001},
                exp_ovf: 4'b0001, exp_status: 32'h0000_0201};
    // Linear: 3x+7 at 0,1,100
    vecs[3] = '{x_base: 10'd30, count: 6'd3, deg: 5'd1,
                c: {16'd0, 16'd0, 16'd3, 16'd7},
                exp_res: {32'd0, 32'd307, 32'd10, 32'd7},
                exp_ovf: 4'b0000, exp_status: 32'h0000_0300};
    // Wrap: x+1 at addresses 1022,1023,0,1
    vecs[4] = '{x_base: 10'd1022, count: 6'd4, deg: 5'd1,
                c: {16'd0, 16'd0, 16'd1, 16'd1},
                exp_res: {32'd6, 32'd3, 32'd5, 32'd4},
                exp_ovf: 4'b0000, exp_status: 32'h0000_0400};

    // reset state
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();
    check_reset_outputs("post_reset");

    for (int n = 0; n < 5; n++) run_vec(vecs[n], n);

    // Backpressure: 3x+7 at x=4 held for five cycles; a start mid-batch is ignored
    cmem[0] = 16'd7;
    cmem[1] = 16'd3;
    res_if.res_ready = 1'b0;
    kick(10'd40, 6'd1, 5'd1);
    c = 0;
    while (!res_if.res_valid && c < 100) begin
      step();
      c++;
    end
    check("bp_latency", c, 4);
    r0 = reads;
    start  = 1'b1;
    count  = 6'd5;
    x_base = 10'd0;
    for (int h = 0; h < 5; h++) begin
      check($sformatf("bp%0d_valid", h), {31'd0, res_if.res_valid}, 32'd1);
      check($sformatf("bp%0d_data", h), res_if.res_data, 32'd19);
      check($sformatf("bp%0d_index", h), {26'd0, res_if.res_index}, 32'd0);
      check($sformatf("bp%0d_ovf", h), {31'd0, res_if.res_ovf}, 32'd0);
      check($sformatf("bp%0d_x_rd_en", h), {31'd0, x_rd_en}, 32'd0);
      step();
    end
    start = 1'b0;
    check("bp_reads", reads, r0);
    res_if.res_ready = 1'b1;
    step();
    check("bp_done", {31'd0, done}, 32'd1);
    step();
    check("bp_status", status, 32'h0000_0100);

    // Bad counts
    bad_count(6'd0);
    bad_count(6'd33);

    // clr wins over start in IDLE
    clr   = 1'b1;
    start = 1'b1;
    count = 6'd2;
    step();
    clr   = 1'b0;
    start = 1'b0;
    check("clr_prio_busy", {31'd0, busy}, 32'd0);
    check("clr_prio_x_rd_en", {31'd0, x_rd_en}, 32'd0);
    check("clr_prio_status", status, 32'd0);

    // Rerun basic so res_data holds a nonzero value, then abort with rst
    run_vec(vecs[0], 10);
    kick(10'd0, 6'd2, 5'd2);
    step();
    step();
    check("rst_abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_abort");
    step();
    rst = 1'b1;
    step();
    run_vec(vecs[0], 11);

    // Same abort with clr
    kick(10'd0, 6'd2, 5'd2);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_reset_outputs("clr_abort");
    run_vec(vecs[0], 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
